// File: rtl/wieg_pkg.sv
// rtl/wieg_pkg.sv - shared types, widths and helpers for the cradle rocking controller
package wieg_pkg;

    localparam int LEVEL_W = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DONE  = 3'd2,
        S_ALARM = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        V_STIJGEN = 2'd0,
        V_GELIJK  = 2'd1,
        V_DALEN   = 2'd2
    } verdict_t;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/stress_venster.sv
// rtl/stress_venster.sv - evaluation window accumulating per-tick stress verdicts
module stress_venster
    import wieg_pkg::*;
#(
    parameter int EVAL_TICKS = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     enable,
    input  logic     slow,
    input  logic     gedaald,
    input  logic     gelijk,
    output logic     verdict_valid,
    output verdict_t verdict
);

    logic [CNT_W-1:0] tick_q, tick_d;
    logic [CNT_W-1:0] dal_q, dal_d;
    logic [CNT_W-1:0] gel_q, gel_d;
    logic [CNT_W-1:0] dal_n, gel_n;
    logic             step;
    logic             last;

    // Fold the current tick into the counts; the closing tick's verdict includes it.
    always_comb begin
        step          = slow && enable;
        dal_n         = gedaald ? sat_inc(dal_q) : dal_q;
        gel_n         = (!gedaald && gelijk) ? sat_inc(gel_q) : gel_q;
        last          = step && (tick_q == CNT_W'(EVAL_TICKS - 1));
        verdict_valid = last && !clear;

        if ({dal_n, 1'b0} >= (CNT_W + 1)'(EVAL_TICKS)) begin
            verdict = V_DALEN;
        end else if ({gel_n, 1'b0} >= (CNT_W + 1)'(EVAL_TICKS)) begin
            verdict = V_GELIJK;
        end else begin
            verdict = V_STIJGEN;
        end

        tick_d = tick_q;
        dal_d  = dal_q;
        gel_d  = gel_q;
        if (clear || last) begin
            tick_d = '0;
            dal_d  = '0;
            gel_d  = '0;
        end else if (step) begin
            tick_d = sat_inc(tick_q);
            dal_d  = dal_n;
            gel_d  = gel_n;
        end
    end

    // Window counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            dal_q  <= '0;
            gel_q  <= '0;
        end else begin
            tick_q <= tick_d;
            dal_q  <= dal_d;
            gel_q  <= gel_d;
        end
    end

endmodule

// File: rtl/wieg_regelaar.sv
// rtl/wieg_regelaar.sv - closed-loop rocking intensity controller for the cradle motor
module wieg_regelaar
    import wieg_pkg::*;
#(
    parameter int EVAL_TICKS   = 8,
    parameter int START_LEVEL  = 3,
    parameter int MAX_LEVEL    = 7,
    parameter int CALM_WINDOWS = 3,
    parameter int FAIL_WINDOWS = 4,
    parameter int ERR_TICKS    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               slow,
    input  logic               start,
    input  logic               stop,
    input  logic               gedaald,
    input  logic               gelijk,
    input  logic               error,
    output logic [LEVEL_W-1:0] level,
    output logic               motor_en,
    output logic               klaar,
    output logic               alarm,
    output logic               fault,
    output logic [2:0]         state
);

    state_t               state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]     calm_q, calm_d, fail_q, fail_d, err_q, err_d;
    logic [CNT_W-1:0]     calm_n, fail_n, err_n;
    logic                 klaar_q, klaar_d;
    logic                 motor_en_q, alarm_q, fault_q;
    logic                 win_clear;
    logic                 verdict_valid;
    verdict_t             verdict;

    stress_venster #(
        .EVAL_TICKS (EVAL_TICKS)
    ) u_venster (
        .clk           (clk),
        .reset         (reset),
        .clear         (win_clear),
        .enable        (state_q == S_RUN),
        .slow          (slow),
        .gedaald       (gedaald),
        .gelijk        (gelijk),
        .verdict_valid (verdict_valid),
        .verdict       (verdict)
    );

    // Next state, intensity and loop counters; stop and fault take precedence over verdicts.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        calm_d    = calm_q;
        fail_d    = fail_q;
        err_d     = err_q;
        klaar_d   = 1'b0;
        win_clear = 1'b0;
        calm_n    = sat_inc(calm_q);
        fail_n    = sat_inc(fail_q);
        err_n     = error ? sat_inc(err_q) : '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d   = S_RUN;
                    level_d   = LEVEL_W'(START_LEVEL);
                    calm_d    = '0;
                    fail_d    = '0;
                    err_d     = '0;
                    win_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    level_d   = '0;
                    calm_d    = '0;
                    fail_d    = '0;
                    err_d     = '0;
                    win_clear = 1'b1;
                end else if (slow) begin
                    err_d = err_n;
                    if (err_n >= CNT_W'(ERR_TICKS)) begin
                        state_d = S_FAULT;
                        level_d = '0;
                    end else if (verdict_valid) begin
                        if (verdict == V_DALEN) begin
                            fail_d = '0;
                            err_d  = '0;
                            calm_d = calm_n;
                            if (calm_n >= CNT_W'(CALM_WINDOWS)) begin
                                calm_d  = '0;
                                level_d = level_q - LEVEL_W'(1);
                                if (level_q == LEVEL_W'(1)) begin
                                    state_d = S_DONE;
                                    klaar_d = 1'b1;
                                end
                            end
                        end else begin
                            calm_d = '0;
                            if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                                fail_d = fail_n;
                                if (fail_n >= CNT_W'(FAIL_WINDOWS)) begin
                                    state_d = S_ALARM;
                                end
                            end else if (verdict == V_STIJGEN) begin
                                level_d = level_q + LEVEL_W'(1);
                            end
                        end
                    end
                end
            end
            S_ALARM, S_FAULT: begin
                if (stop) begin
                    state_d = S_IDLE;
                    level_d = '0;
                    calm_d  = '0;
                    fail_d  = '0;
                    err_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            level_q    <= '0;
            calm_q     <= '0;
            fail_q     <= '0;
            err_q      <= '0;
            klaar_q    <= 1'b0;
            motor_en_q <= 1'b0;
            alarm_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            calm_q     <= calm_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            klaar_q    <= klaar_d;
            motor_en_q <= (state_d == S_RUN) || (state_d == S_ALARM);
            alarm_q    <= (state_d == S_ALARM);
            fault_q    <= (state_d == S_FAULT);
        end
    end

    assign level    = level_q;
    assign motor_en = motor_en_q;
    assign klaar    = klaar_q;
    assign alarm    = alarm_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_wieg_regelaar.sv
// tb/tb_wieg_regelaar.sv - randomized scoreboard bench for wieg_regelaar
module tb_wieg_regelaar;

    localparam int EVAL = 8, START = 3, MAXL = 7, CALM = 3, FAILW = 4, ERRT = 3;
    localparam int IDLE = 0, RUN = 1, DONE = 2, ALARM = 3, FAULT = 4;

    logic       clk = 1'b0;
    logic       reset, slow, start, stop, gedaald, gelijk, error;
    logic [2:0] level, state;
    logic       motor_en, klaar, alarm, fault;

    wieg_regelaar dut (
        .clk      (clk),
        .reset    (reset),
        .slow     (slow),
        .start    (start),
        .stop     (stop),
        .gedaald  (gedaald),
        .gelijk   (gelijk),
        .error    (error),
        .level    (level),
        .motor_en (motor_en),
        .klaar    (klaar),
        .alarm    (alarm),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int lvl;
        bit en;
        bit kl;
        bit al;
        bit fl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc_no   = 0;

    // Reference model state: window kept as the list of tick kinds seen so far.
    int m_st = IDLE, m_lvl = 0, m_calm = 0, m_fail = 0, m_err = 0;
    bit m_klaar = 0;
    int m_win[$];

    task automatic m_clear();
        m_calm = 0; m_fail = 0; m_err = 0;
        m_win.delete();
    endtask

    task automatic model_step(input bit r, st, sp, sl, g, gl, e);
        int nd, ng;
        m_klaar = 0;
        if (r) begin
            m_st = IDLE; m_lvl = 0; m_clear();
        end else begin
            case (m_st)
                IDLE, DONE: begin
                    if (sp) m_st = IDLE;
                    else if (st) begin m_st = RUN; m_lvl = START; m_clear(); end
                end
                RUN: begin
                    if (sp) begin
                        m_st = IDLE; m_lvl = 0; m_clear();
                    end else if (sl) begin
                        m_err = e ? ((m_err < 15) ? m_err + 1 : 15) : 0;
                        m_win.push_back(g ? 2 : (gl ? 1 : 0));
                        if (m_err >= ERRT) begin
                            m_st = FAULT; m_lvl = 0;
                        end else if (m_win.size() == EVAL) begin
                            nd = 0; ng = 0;
                            foreach (m_win[i]) begin
                                if (m_win[i] == 2) nd++;
                                if (m_win[i] == 1) ng++;
                            end
                            m_win.delete();
                            if (2 * nd >= EVAL) begin
                                m_err = 0; m_fail = 0; m_calm++;
                                if (m_calm == CALM) begin
                                    m_calm = 0;
                                    m_lvl--;
                                    if (m_lvl == 0) begin m_st = DONE; m_klaar = 1; end
                                end
                            end else begin
                                m_calm = 0;
                                if (m_lvl == MAXL) begin
                                    m_fail++;
                                    if (m_fail == FAILW) m_st = ALARM;
                                end else if (2 * ng < EVAL) begin
                                    m_lvl++;
                                end
                            end
                        end
                    end
                end
                default: begin
                    if (sp) begin m_st = IDLE; m_lvl = 0; m_clear(); end
                end
            endcase
        end
    endtask

    task automatic cyc(input bit r, st, sp, sl, g, gl, e);
        exp_t x;
        @(negedge clk);
        reset = r; start = st; stop = sp; slow = sl;
        gedaald = g; gelijk = gl; error = e;
        model_step(r, st, sp, sl, g, gl, e);
        x.st  = m_st;
        x.lvl = m_lvl;
        x.en  = (m_st == RUN) || (m_st == ALARM);
        x.kl  = m_klaar;
        x.al  = (m_st == ALARM);
        x.fl  = (m_st == FAULT);
        exp_q.push_back(x);
    endtask

    // Monitor: outputs settle after each edge; compare against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                cyc_no++;
                n_checks++;
                if (int'(state) == x.st && int'(level) == x.lvl && motor_en == x.en &&
                    klaar == x.kl && alarm == x.al && fault == x.fl) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs cycle %0d: got state=%0d level=%0d en=%0b klaar=%0b alarm=%0b fault=%0b, expected state=%0d level=%0d en=%0b klaar=%0b alarm=%0b fault=%0b",
                             cyc_no, state, level, motor_en, klaar, alarm, fault,
                             x.st, x.lvl, x.en, x.kl, x.al, x.fl);
                end
            end
        end
    end

    // Stimulus segments: 0 calm, 1 no-change escalation, 2 errors, 3 mixed random, 4 near-majority.
    int modes[12] = '{0, 1, 2, 4, 3, 0, 1, 4, 2, 3, 4, 3};

    initial begin
        bit sl, g, gl, e, st, sp, r;
        reset = 1'b1; start = 1'b0; stop = 1'b0; slow = 1'b0;
        gedaald = 1'b0; gelijk = 1'b0; error = 1'b0;
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        foreach (modes[s]) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            cyc(0, 1, 1, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0, 0, 0);
            for (int k = 0; k < ((modes[s] == 3) ? 500 : 180); k++) begin
                r = 0; st = 0; sp = 0; e = 0;
                case (modes[s])
                    0: begin sl = 1; g = ($urandom_range(0, 9) != 0); gl = $urandom_range(0, 1); end
                    1: begin sl = 1; g = 0; gl = ($urandom_range(0, 3) == 0); end
                    2: begin sl = 1; g = $urandom_range(0, 1); gl = $urandom_range(0, 1);
                             e = $urandom_range(0, 1); end
                    4: begin sl = $urandom_range(0, 1); g = $urandom_range(0, 1);
                             gl = $urandom_range(0, 1); e = ($urandom_range(0, 9) == 0); end
                    default: begin
                        sl = $urandom_range(0, 1); g = $urandom_range(0, 1);
                        gl = $urandom_range(0, 1); e = ($urandom_range(0, 7) == 0);
                        st = ($urandom_range(0, 7) == 0); sp = ($urandom_range(0, 99) == 0);
                        r  = ($urandom_range(0, 299) == 0);
                    end
                endcase
                cyc(r, st, sp, sl, g, gl, e);
            end
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
